// File: rtl/regfile_dump_tx_pkg.sv
// Shared constants for the register-file debug dump path.
// Default geometry is shared with the register file and debug UART blocks.
// State encoding of the dump sequencer lives here so monitors can decode it.
package regfile_dump_tx_pkg;

    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_DATA_W     = 32;
    localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_dump_tx_word_serializer.sv
// Word serializer: loads a DATA_W word and emits it as bytes, MSB first.
// Latency: first byte valid the cycle after load_i; one byte per cycle thereafter.
// Backpressure: tx_data_o/tx_valid_o hold while tx_ready_i is low; valid never drops without a transfer.
module regfile_dump_tx_word_serializer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              tx_ready_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    output logic              last_byte_o
);

    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BPW - 1);

    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;
    logic              xfer;

    assign xfer        = valid_q && tx_ready_i;
    assign last_byte_o = valid_q && (cnt_q == LAST_IDX);
    // The top byte of the shift register is the registered output byte.
    assign tx_data_o   = shreg_q[DATA_W-1 -: 8];
    assign tx_valid_o  = valid_q;

    // Load a word, then shift one byte out per accepted transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shreg_q <= data_i;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (xfer) begin
            if (cnt_q == LAST_IDX) begin
                // Keep the last byte on the bus; only valid drops.
                valid_q <= 1'b0;
            end else begin
                shreg_q <= shreg_q << 8;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_dump_tx.sv
// Register dump sequencer: walks the debug read port and streams every register as bytes.
// Latency: first byte valid READ_LAT+1 cycles after start is sampled; READ_LAT+1 idle cycles between words.
// Backpressure: byte stream stalls in place while tx_ready is low; start is ignored while busy or done.
module regfile_dump_tx
    import regfile_dump_tx_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] regdbg_data,
    input  logic              tx_ready,
    output logic              debug_on,
    output logic [ADDR_W-1:0] regdbg_addr,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              busy,
    output logic              done
);

    localparam int WAIT_W = 2;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              debug_on_q, debug_on_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;
    logic              last_byte;
    logic              xfer_last;
    logic              start_ok;

    assign load      = (state_q == ST_LOAD);
    assign xfer_last = last_byte && tx_ready;
    // A start arriving in the done-pulse cycle belongs to the dump just finished.
    assign start_ok  = start && !done_q;

    regfile_dump_tx_word_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .data_i      (regdbg_data),
        .tx_ready_i  (tx_ready),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .last_byte_o (last_byte)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            addr_q     <= '0;
            debug_on_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            debug_on_q <= debug_on_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_WAIT;
            ST_WAIT: if (wait_q == '0) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: if (xfer_last) state_d = (addr_q < LAST_ADDR) ? ST_WAIT : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered control outputs and counters.
    always_comb begin
        wait_d     = wait_q;
        addr_d     = addr_q;
        debug_on_d = debug_on_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    debug_on_d = 1'b1;
                    busy_d     = 1'b1;
                    addr_d     = '0;
                    wait_d     = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (wait_q != '0) wait_d = wait_q - 1'b1;
            end
            ST_SEND: begin
                // Address advances only after the whole word left; it stops at the last register.
                if (xfer_last && (addr_q < LAST_ADDR)) begin
                    addr_d = addr_q + 1'b1;
                    wait_d = WAIT_INIT;
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                debug_on_d = 1'b0;
                busy_d     = 1'b0;
                addr_d     = '0;
            end
            default: ;
        endcase
    end

    assign debug_on    = debug_on_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign regdbg_addr = addr_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
module tb_regfile_dump_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, tx_ready_a, tx_ready_b;
    logic [31:0] rd_a, rd_b1, rd_b2;
    logic        debug_on_a, tx_valid_a, busy_a, done_a;
    logic        debug_on_b, tx_valid_b, busy_b, done_b;
    logic [4:0]  addr_a, addr_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic [31:0] regs [0:31];
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_b [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Register file debug port model: output updates on negedge, B has one extra stage.
    always @(negedge clk) begin
        rd_a  <= regs[addr_a];
        rd_b1 <= regs[addr_b];
        rd_b2 <= rd_b1;
    end

    regfile_dump_tx #(.READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .regdbg_data(rd_a), .tx_ready(tx_ready_a),
        .debug_on(debug_on_a), .regdbg_addr(addr_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .busy(busy_a), .done(done_a));

    regfile_dump_tx #(.READ_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .regdbg_data(rd_b2), .tx_ready(tx_ready_b),
        .debug_on(debug_on_b), .regdbg_addr(addr_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .busy(busy_b), .done(done_b));

    task automatic init_regs();
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i * 32'h0001_0203;
        regs[0]  = 32'h0000_0001;
        regs[1]  = 32'h0000_0011;
        regs[8]  = 32'h0000_0004;
        regs[31] = 32'h0000_002A;
    endtask

    task automatic push_dump(input bit to_b);
        logic [31:0] w;
        for (int r = 0; r < 32; r++) begin
            w = regs[r];
            for (int b = 3; b >= 0; b--) begin
                if (to_b) exp_b.push_back(w[8*b +: 8]);
                else      exp_q.push_back(w[8*b +: 8]);
            end
        end
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    // Runs one dump on instance A, popping the scoreboard on every accepted byte.
    task automatic drain(input int rdy_mode, input bit extra_start, input int limit,
                         output int nbytes, output int nbad, output int unstable, output int ndone,
                         output int done_cyc, output int addr_bad, output int busy_bad,
                         output int post_bad, output bit timeout);
        int         cyc, prev_addr, post;
        bit         stall;
        logic [7:0] held, e;
        nbytes = 0; nbad = 0; unstable = 0; ndone = 0; done_cyc = -1;
        addr_bad = 0; busy_bad = 0; post_bad = 0; timeout = 1'b0;
        cyc = 0; prev_addr = 0; post = 0; stall = 1'b0; held = 8'h00;
        while (1) begin
            start_a    = extra_start && (cyc == 10);
            tx_ready_a = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            @(negedge clk);
            if (stall && (tx_valid_a !== 1'b1 || tx_data_a !== held)) unstable++;
            if (ndone == 0) begin
                if (done_a !== 1'b1) begin
                    if (busy_a !== 1'b1 || debug_on_a !== 1'b1) busy_bad++;
                    if (int'(addr_a) < prev_addr || int'(addr_a) > prev_addr + 1) addr_bad++;
                    prev_addr = int'(addr_a);
                end
            end else begin
                post++;
                if (busy_a !== 1'b0 || tx_valid_a !== 1'b0 || debug_on_a !== 1'b0) post_bad++;
            end
            if (done_a === 1'b1) begin
                ndone++;
                if (ndone == 1) done_cyc = cyc;
                if (extra_start) start_a = 1'b1;
            end
            if (tx_valid_a === 1'b1 && tx_ready_a) begin
                nbytes++;
                if (exp_q.size() == 0) nbad++;
                else begin
                    e = exp_q.pop_front();
                    if (e !== tx_data_a) nbad++;
                end
            end
            stall = (tx_valid_a === 1'b1) && !tx_ready_a;
            held  = tx_data_a;
            if (post >= 20) break;
            if (cyc >= limit) begin timeout = 1'b1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0;
        tx_ready_a = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({tx_valid_a, debug_on_a, busy_a, done_a} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0000", {tx_valid_a, debug_on_a, busy_a, done_a});
        end
        checks++;
        if (addr_a !== 5'd0 || tx_data_a !== 8'h00) begin
            failures++; $display("FAIL reset_addr_data got addr=%0d data=%h want 0/00", addr_a, tx_data_a);
        end
        checks++;
        if ({tx_valid_b, debug_on_b, busy_b, done_b} !== 4'b0000) begin
            failures++; $display("FAIL reset_b_ctrl got=%b want=0000", {tx_valid_b, debug_on_b, busy_b, done_b});
        end
    endtask

    task automatic test_basic();
        int nb, nbad, uns, nd, dc, ab, bb, pb; bit to;
        exp_q.delete(); push_dump(1'b0);
        pulse_start_a();
        drain(0, 1'b0, 400, nb, nbad, uns, nd, dc, ab, bb, pb, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout got=1 want=0"); end
        checks++; if (nb != 128) begin failures++; $display("FAIL basic_bytes got=%0d want=128", nb); end
        checks++; if (nbad != 0) begin failures++; $display("FAIL basic_data mismatches=%0d want=0", nbad); end
        checks++; if (nd != 1) begin failures++; $display("FAIL basic_done_count got=%0d want=1", nd); end
        checks++; if (dc != 193) begin failures++; $display("FAIL basic_latency got=%0d want=193", dc); end
        checks++; if (bb != 0) begin failures++; $display("FAIL basic_busy_low got=%0d want=0", bb); end
        checks++; if (ab != 0 || pb != 0) begin failures++; $display("FAIL basic_addr_post got=%0d/%0d want=0/0", ab, pb); end
    endtask

    task automatic test_backpressure();
        int nb, nbad, uns, nd, dc, ab, bb, pb; bit to;
        exp_q.delete(); push_dump(1'b0);
        pulse_start_a();
        drain(1, 1'b0, 1200, nb, nbad, uns, nd, dc, ab, bb, pb, to);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout got=1 want=0"); end
        checks++; if (nb != 128 || nbad != 0) begin failures++; $display("FAIL bp_stream got bytes=%0d bad=%0d want 128/0", nb, nbad); end
        checks++; if (uns != 0) begin failures++; $display("FAIL bp_stable got=%0d want=0", uns); end
        checks++; if (nd != 1 || bb != 0) begin failures++; $display("FAIL bp_done_busy got=%0d/%0d want=1/0", nd, bb); end
    endtask

    task automatic test_extra_start();
        int nb, nbad, uns, nd, dc, ab, bb, pb; bit to;
        exp_q.delete(); push_dump(1'b0);
        pulse_start_a();
        drain(0, 1'b1, 400, nb, nbad, uns, nd, dc, ab, bb, pb, to);
        checks++; if (nb != 128 || nbad != 0 || to) begin failures++; $display("FAIL xstart_stream got bytes=%0d bad=%0d to=%0d want 128/0/0", nb, nbad, to); end
        checks++; if (nd != 1) begin failures++; $display("FAIL xstart_done got=%0d want=1", nd); end
        checks++; if (pb != 0) begin failures++; $display("FAIL xstart_restart got=%0d want=0", pb); end
    endtask

    task automatic test_reset_mid();
        int n, nb, nbad, uns, nd, dc, ab, bb, pb; bit got, to;
        logic [31:0] w;
        logic [7:0]  e;
        exp_q.delete(); tx_ready_a = 1'b1;
        pulse_start_a();
        n = 0; got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx_valid_a === 1'b1 && tx_ready_a) n++;
            @(posedge clk); #1;
            if (n == 22) begin got = 1'b1; tx_ready_a = 1'b0; break; end
        end
        checks++; if (!got) begin failures++; $display("FAIL rstmid_reach got=%0d bytes want=22", n); end
        w = regs[5]; e = w[15:8];
        checks++;
        if (tx_valid_a !== 1'b1 || tx_data_a !== e || addr_a !== 5'd5) begin
            failures++; $display("FAIL rstmid_pending got v=%b d=%h a=%0d want 1/%h/5", tx_valid_a, tx_data_a, addr_a, e);
        end
        rst = 1'b0; #1;
        checks++;
        if ({tx_valid_a, debug_on_a, busy_a, done_a} !== 4'b0000 || addr_a !== 5'd0) begin
            failures++; $display("FAIL rstmid_async got=%b addr=%0d want=0000 addr=0", {tx_valid_a, debug_on_a, busy_a, done_a}, addr_a);
        end
        @(negedge clk); rst = 1'b1; tx_ready_a = 1'b1;
        push_dump(1'b0);
        pulse_start_a();
        drain(0, 1'b0, 400, nb, nbad, uns, nd, dc, ab, bb, pb, to);
        checks++; if (nb != 128 || nbad != 0 || nd != 1 || to) begin failures++; $display("FAIL rstmid_redump got bytes=%0d bad=%0d done=%0d want 128/0/1", nb, nbad, nd); end
    endtask

    task automatic test_write_reg9();
        int nb, nbad, uns, nd, dc, ab, bb, pb; bit to;
        regs[9] = 32'hDEAD_BEEF;
        exp_q.delete(); push_dump(1'b0);
        pulse_start_a();
        drain(0, 1'b0, 400, nb, nbad, uns, nd, dc, ab, bb, pb, to);
        checks++; if (nb != 128 || nbad != 0 || to) begin failures++; $display("FAIL reg9_stream got bytes=%0d bad=%0d want 128/0", nb, nbad); end
        checks++; if (ab != 0) begin failures++; $display("FAIL reg9_addr_order got=%0d want=0", ab); end
    endtask

    task automatic test_read_lat2();
        int cyc, nb, nbad, dc;
        logic [7:0] e;
        exp_b.delete(); push_dump(1'b1);
        tx_ready_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        cyc = 0; nb = 0; nbad = 0; dc = -1;
        while (cyc < 600) begin
            @(negedge clk);
            if (tx_valid_b === 1'b1) begin
                nb++;
                if (exp_b.size() == 0) nbad++;
                else begin
                    e = exp_b.pop_front();
                    if (e !== tx_data_b) nbad++;
                end
            end
            if (done_b === 1'b1) begin dc = cyc; break; end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (nb != 128 || nbad != 0) begin failures++; $display("FAIL lat2_stream got bytes=%0d bad=%0d want 128/0", nb, nbad); end
        checks++; if (dc != 225) begin failures++; $display("FAIL lat2_latency got=%0d want=225", dc); end
    endtask

    initial begin
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; tx_ready_a = 1'b1; tx_ready_b = 1'b1;
        init_regs();
        #12;
        test_reset();
        @(negedge clk); rst = 1'b1;
        test_basic();
        test_backpressure();
        test_extra_start();
        test_reset_mid();
        test_write_reg9();
        test_read_lat2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_dump_tx.md
Name: regfile_dump_tx

Overview:
- Debug-side reader for the register file's debug read port.
- On a start pulse it asserts debug_on and walks regdbg_addr over 0..NUM_REGS-1.
- It captures each 32-bit value from regdbg_data and streams it as bytes, MSB first, on a valid/ready byte interface.
- Sits between the register file and the debug UART transmitter; feeds the host-side register dump.

Parameters:
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1).
- ADDR_W, 5, width of regdbg_addr; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 32, register width; must be a multiple of 8.
- READ_LAT, 1, posedges from an address change to valid regdbg_data (register file updates its debug output on negedge); range 1..3.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to dump all registers; sampled only in IDLE.
- regdbg_data  in  DATA_W  debug read data from the register file.
- tx_ready  in  1  byte sink ready.
- debug_on  out  1  debug read enable to the register file; high for the whole dump.
- regdbg_addr  out  ADDR_W  debug read address.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; debug_on, tx_valid, busy and done are 0; regdbg_addr=0; tx_data=0; byte and wait counters are 0. All outputs are registered.
- States: IDLE, WAIT, LOAD, SEND, DONE.
- IDLE:
  - start=1 at posedge S: go to WAIT; debug_on=1, busy=1, regdbg_addr=0, wait counter=READ_LAT-1.
  - start=0: stay in IDLE.
- WAIT:
  - Counter nonzero: decrement it.
  - Counter zero: go to LOAD.
  - With READ_LAT=1, WAIT lasts exactly one cycle.
- LOAD:
  - Capture regdbg_data into a DATA_W shift register.
  - Drive tx_data=captured[DATA_W-1:DATA_W-8], set tx_valid=1, byte counter=0, go to SEND.
  - With READ_LAT=1, the first tx_valid is high in the cycle after posedge S+2.
- SEND, handshake:
  - A byte transfers on a posedge where tx_valid && tx_ready.
  - While tx_valid=1 && tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer.
- SEND, on transfer with byte counter < DATA_W/8-1:
  - Shift the register left by 8 and load the next byte into tx_data.
  - Increment the byte counter; tx_valid stays 1, giving back-to-back bytes at one per cycle when tx_ready is held high.
- SEND, on transfer of the last byte:
  - tx_valid=0.
  - If regdbg_addr < NUM_REGS-1: regdbg_addr+1, counter=READ_LAT-1, go to WAIT.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle; debug_on=0, busy=0, regdbg_addr=0; go to IDLE. start is ignored in this cycle.
- start asserted while busy is ignored; it is neither queued nor restarts the dump.
- Address wrap: the address never exceeds NUM_REGS-1; no modulo wrap is used.
- Reset mid-dump: immediate return to the reset values. A partially sent register is abandoned and the sink sees tx_valid drop.
- Output totals:
  - Bytes per dump: NUM_REGS*DATA_W/8 (128 by default).
  - Minimum cycles from start to done (tx_ready=1 always): NUM_REGS*(READ_LAT+1+DATA_W/8)+1.

Decomposition:
- Shared debug package holds:
  - state encoding constants (IDLE=0, WAIT=1, LOAD=2, SEND=3, DONE=4);
  - BYTES_PER_WORD = DATA_W/8;
  - the default NUM_REGS/ADDR_W/DATA_W values, shared with the register file and UART blocks.
- One natural sub-module: word_serializer.
  - Function: DATA_W shift register plus byte counter with the valid/ready output.
  - Interface: load/data in, last_byte out.
- The FSM stays in regfile_dump_tx.

Test Plan:
1. Register file freshly reset (reg0=0x00000001, reg1=0x00000011, reg8=0x00000004, reg31=0x0000002A), tx_ready=1, start pulse -> bytes exactly 00 00 00 01, 00 00 00 11, ..., 00 00 00 2A; 128 bytes total; done pulses once after cycle 193; busy and debug_on high throughout.
2. tx_ready toggled 1-cycle-on/2-cycles-off -> same 128-byte sequence; tx_data stable whenever tx_valid=1 && tx_ready=0; no byte dropped or duplicated.
3. Second start pulse 10 cycles into a dump, plus one in the done cycle -> still exactly one dump of 128 bytes and one done pulse.
4. rst=0 asserted while the 3rd byte of reg5 is pending -> tx_valid, debug_on and busy are 0 immediately and regdbg_addr=0; a later start produces a complete dump beginning 00 00 00 01.
5. Write reg9=0xDEADBEEF through the normal write port before start -> reg9 is sent as DE AD BE EF; regdbg_addr observed 0..31 in order, never 32.
6. READ_LAT=2 build with the register-file model delayed one extra cycle -> correct byte stream; minimum start-to-done of 225 cycles with tx_ready=1.
